// File: rtl/control_bus_rtc.sv
// control_bus_rtc: runs one multiplexed address/data cycle on the RTC parallel bus per sequencer request
module control_bus_rtc #(
  parameter int         T_FASE    = 4,
  parameter logic [7:0] INIT_ADDR = 8'h02,
  parameter logic [7:0] INIT_DATA = 8'h10,
  parameter logic [7:0] ADDR_P0   = 8'h21,
  parameter logic [7:0] ADDR_P1   = 8'h22,
  parameter logic [7:0] ADDR_P2   = 8'h23,
  parameter logic [7:0] ADDR_P3   = 8'hF0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_inicio,
  input  logic       enable_escribir,
  input  logic       enable_leer,
  input  logic [1:0] posicion,
  input  logic [7:0] dato_escribir,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] dato_leido,
  output logic       dato_valido,
  output logic       listo
);
  localparam int CW = $clog2(T_FASE) + 1;
  typedef enum logic [3:0] {
    IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, DATA_SETUP, DATA_STROBE, DATA_HOLD, DONE, RECOVER
  } state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic es_lect;
  logic [7:0] dir, dato, addr_pos, out_d;
  logic req, phase_end, addr_ph, data_ph, drive_d;
  assign req       = enable_inicio | enable_escribir | enable_leer;
  assign phase_end = cnt == CW'(T_FASE - 1);
  assign addr_pos  = posicion[1] ? (posicion[0] ? ADDR_P3 : ADDR_P2) : (posicion[0] ? ADDR_P1 : ADDR_P0);
  assign addr_ph   = state inside {ADDR_SETUP, ADDR_STROBE, ADDR_HOLD};
  assign data_ph   = state inside {DATA_SETUP, DATA_STROBE, DATA_HOLD};
  assign drive_d   = addr_ph | (data_ph & ~es_lect);
  assign out_d     = addr_ph ? dir : drive_d ? dato : 8'h00;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = req ? ADDR_SETUP : IDLE;
      DONE:    state_nx = RECOVER;
      RECOVER: state_nx = phase_end ? IDLE : RECOVER;
      default: state_nx = phase_end ? state_t'(state + 4'd1) : state;
    endcase
  end
  // Bus pins are decoded from the current state and registered, so they trail the state by one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      es_lect     <= 1'b0;
      dir         <= 8'h00;
      dato        <= 8'h00;
      ad_out      <= 8'h00;
      ad_oe       <= 1'b0;
      cs_n        <= 1'b1;
      rd_n        <= 1'b1;
      wr_n        <= 1'b1;
      a_d         <= 1'b0;
      dato_leido  <= 8'h00;
      dato_valido <= 1'b0;
      listo       <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= (state_nx != state || state == IDLE) ? '0 : cnt + CW'(1);
      ad_out      <= out_d;
      ad_oe       <= drive_d;
      cs_n        <= ~(addr_ph | data_ph);
      rd_n        <= ~(state == DATA_STROBE && es_lect);
      wr_n        <= ~(state == ADDR_STROBE || (state == DATA_STROBE && !es_lect));
      a_d         <= data_ph;
      dato_valido <= state == DONE && es_lect;
      listo       <= state == DONE;
      if (state == IDLE && req) begin
        es_lect <= ~enable_inicio & ~enable_escribir;
        dir     <= enable_inicio ? INIT_ADDR : addr_pos;
        dato    <= enable_inicio ? INIT_DATA : dato_escribir;
      end
      if (state == DATA_STROBE && es_lect && phase_end) dato_leido <= ad_in;
    end
  end
endmodule

// File: doc/control_bus_rtc.md
Name: control_bus_rtc

Overview:
- Bus-transaction engine that sits directly downstream of the FSM sequencer.
- Consumes the sequencer's enable_inicio / enable_escribir / enable_leer and posicion, and runs one multiplexed address/data cycle on the RTC parallel bus.
- Returns a one-cycle listo pulse so the sequencer can advance.
- On reads, latches the byte returned by the RTC for the display/storage stage.

Parameters:
T_FASE, 4, clock cycles per bus phase (>=1); counter width = clog2(T_FASE)+1
INIT_ADDR, 8'h02, register address written by an init transaction
INIT_DATA, 8'h10, data byte written by an init transaction
ADDR_P0, 8'h21, address for posicion 0 (seconds)
ADDR_P1, 8'h22, address for posicion 1 (minutes)
ADDR_P2, 8'h23, address for posicion 2 (hours)
ADDR_P3, 8'hF0, address for posicion 3 (transfer/command)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
enable_inicio  in  1  level request: init write
enable_escribir  in  1  level request: write dato_escribir to address(posicion)
enable_leer  in  1  level request: read address(posicion)
posicion  in  2  register select
dato_escribir  in  8  write data
ad_in  in  8  bus value from pad (read data)
ad_out  out  8  bus drive value
ad_oe  out  1  pad output enable (1 = drive ad_out)
cs_n  out  1  chip select, active-low
rd_n  out  1  read strobe, active-low
wr_n  out  1  write strobe, active-low
a_d  out  1  0 = address phase, 1 = data phase
dato_leido  out  8  last byte read
dato_valido  out  1  one-cycle pulse with listo on read transactions
listo  out  1  one-cycle transaction-complete pulse

Behaviour:
- Reset (reset=0, immediate, asynchronous):
  - state=IDLE, counter=0.
  - cs_n=rd_n=wr_n=1, a_d=0, ad_oe=0, ad_out=0, dato_leido=0, dato_valido=0, listo=0.
- States: IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, DATA_SETUP, DATA_STROBE, DATA_HOLD, DONE, RECOVER.
  - Every state except IDLE and DONE lasts exactly T_FASE cycles.
  - DONE lasts 1 cycle.
- IDLE:
  - Samples enables each edge. Priority: inicio > escribir > leer.
  - On any enable, latch at that edge: type, address (INIT_ADDR for inicio, else ADDR_Pn by posicion), and write data (INIT_DATA or dato_escribir).
  - Then go to ADDR_SETUP.
  - No enable: stay in IDLE.
- ADDR_SETUP: cs_n=0, a_d=0, ad_oe=1, ad_out=latched address.
- ADDR_STROBE: as ADDR_SETUP, plus wr_n=0.
- ADDR_HOLD: wr_n=1; address still driven.
- DATA_SETUP: a_d=1.
  - Write: ad_oe=1, ad_out=latched data.
  - Read: ad_oe=0.
- DATA_STROBE:
  - Write: wr_n=0.
  - Read: rd_n=0; ad_in is captured into dato_leido on the final edge of the phase.
- DATA_HOLD: strobes high; cs_n still 0.
- DONE:
  - cs_n=1, ad_oe=0, listo=1.
  - dato_valido=1 only if the transaction was a read.
- RECOVER: cs_n=1, bus idle. Gives the sequencer time to update its enables. Then go to IDLE.
- Latency:
  - Request sampled in IDLE at edge k.
  - listo is high for the cycle following edge k+6*T_FASE+1.
  - Next request can be sampled no earlier than edge k+7*T_FASE+2.
- Once started, a transaction always completes:
  - Enable deassertion or a posicion/dato_escribir change mid-transaction has no effect.
  - An enable still high in IDLE after RECOVER starts a new transaction. This is intentional back-to-back operation.
- Simultaneous enables resolve by priority. The lower-priority requests are not queued.
- dato_leido holds its value until the next read completes. Write and init transactions never modify it.
- rd_n and wr_n are never low in the same cycle. ad_oe is never 1 while rd_n=0.
- All outputs are registered (no combinational path from inputs to outputs).

Test Plan:
- Reset, then pulse enable_inicio (T_FASE=4):
  - bus sequence is address 8'h02 with a_d=0 and a 4-cycle wr_n low, then data 8'h10 with a_d=1 and a 4-cycle wr_n low;
  - listo pulses once, exactly 25 edges after the sampling edge;
  - dato_valido stays 0.
- enable_escribir=1, posicion=2, dato_escribir=8'h45, held until listo:
  - address phase drives 8'h23, data phase drives 8'h45;
  - a second transaction starts only after RECOVER (4 cycles with cs_n=1).
- enable_leer=1, posicion=1, ad_in=8'h37 during DATA_STROBE:
  - ad_oe=0 throughout the data phase, rd_n low for 4 cycles;
  - dato_leido=8'h37, and dato_valido and listo are high in the same single cycle.
- enable_inicio, enable_escribir and enable_leer all asserted together: only the init transaction runs (address 8'h02); dato_leido is unchanged.
- Change posicion 0->3 and drop enable_escribir during ADDR_STROBE: the transaction completes with the originally latched address 8'h21 and data.
- Drive reset=0 mid DATA_STROBE:
  - all outputs return to their reset values immediately, without waiting for a clock edge;
  - no listo pulse occurs;
  - after release, a new enable_leer runs a full, correct transaction.
